fetch_queue: RTL and testbench

Instruction-fetch front end with a PC register, an in-order request/response interface to instruction memory, and a DEPTH-entry fetch queue that decouples memory latency from decode. Sits directly upstream of decode: `ID_INSTR` drives the immediate extender's `IMM_IN`, and `ID_OPCODE` drives its `opcode`. It absorbs decode stalls and discards wrong-path fetches on a branch/jump redirect from EX.

---
 rtl/fetch_queue.sv | 143 ++++++++++++++
 tb/tb_fetch_queue.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch front end: PC, in-order imem req/resp, DEPTH-slot fetch queue
// Optional FETCH_PERF_EN adds FETCH_CNT (pops) and DROP_CNT (discarded responses).
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  input  logic        ID_READY,
  output logic        ID_VALID,
  output logic [31:0] ID_INSTR,
  output logic [31:0] ID_PC,
  output logic [4:0]  ID_OPCODE
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] FETCH_CNT,
  output logic [31:0] DROP_CNT
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] alloc_q, alloc_d, fill_q, fill_d, head_q, head_d;
  logic [CW-1:0] occ_q, occ_d, pend_q, pend_d, drop_q, drop_d, drop_sum;
  logic [31:0]   slot_pc_q    [DEPTH];
  logic [31:0]   slot_instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q;

  logic grant, fill_en, dropping, pop, rv_live;

  assign IMEM_REQ  = (occ_q < CW'(DEPTH)) & ~RST;
  assign IMEM_ADDR = RST ? {RESET_PC[31:2], 2'b00} : pc_q;
  assign grant     = IMEM_REQ & IMEM_GNT;
  // pend_q counts reserved slots still waiting for their response
  assign dropping  = IMEM_RVALID & (drop_q != '0);
  assign rv_live   = IMEM_RVALID & (drop_q == '0) & (pend_q != '0);
  assign fill_en   = rv_live & ~REDIRECT;

  assign ID_VALID  = filled_q[head_q] & (occ_q != '0);
  assign ID_INSTR  = slot_instr_q[head_q];
  assign ID_PC     = slot_pc_q[head_q];
  assign ID_OPCODE = slot_instr_q[head_q][6:2];
  assign pop       = ID_VALID & ID_READY & ~REDIRECT;

  // Everything in flight at a redirect becomes a response to throw away
  assign drop_sum  = drop_q + pend_q + CW'(grant);

  always_comb begin
    pc_d    = pc_q;
    alloc_d = alloc_q;
    fill_d  = fill_q;
    head_d  = head_q;
    occ_d   = occ_q;
    pend_d  = pend_q;
    drop_d  = drop_q;
    if (REDIRECT) begin
      pc_d    = {REDIRECT_PC[31:2], 2'b00};
      alloc_d = '0;
      fill_d  = '0;
      head_d  = '0;
      occ_d   = '0;
      pend_d  = '0;
      drop_d  = drop_sum - CW'(dropping | rv_live);
    end else begin
      if (grant) begin
        alloc_d = alloc_q + AW'(1);
        pc_d    = pc_q + 32'd4;
      end
      if (fill_en) fill_d = fill_q + AW'(1);
      if (pop) head_d = head_q + AW'(1);
      if (dropping) drop_d = drop_q - CW'(1);
      occ_d  = occ_q + CW'(grant) - CW'(pop);
      pend_d = pend_q + CW'(grant) - CW'(fill_en);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q     <= {RESET_PC[31:2], 2'b00};
      alloc_q  <= '0;
      fill_q   <= '0;
      head_q   <= '0;
      occ_q    <= '0;
      pend_q   <= '0;
      drop_q   <= '0;
      filled_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_pc_q[i]    <= '0;
        slot_instr_q[i] <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
      head_q  <= head_d;
      occ_q   <= occ_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      if (REDIRECT) begin
        filled_q <= '0;
      end else begin
        if (grant) begin
          slot_pc_q[alloc_q] <= pc_q;
          filled_q[alloc_q]  <= 1'b0;
        end
        if (fill_en) begin
          slot_instr_q[fill_q] <= IMEM_RDATA;
          filled_q[fill_q]     <= 1'b1;
        end
        if (pop) filled_q[head_q] <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, dropc_q;
  logic        discard;

  assign discard   = dropping | (REDIRECT & rv_live);
  assign FETCH_CNT = fetch_cnt_q;
  assign DROP_CNT  = dropc_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_cnt_q <= '0;
      dropc_q     <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_q + 32'(pop);
      dropc_q     <= dropc_q + 32'(discard);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized scoreboard bench for fetch_queue
module tb_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam int          NCYC  = 1800;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT;
  logic        IMEM_RVALID;
  logic [31:0] IMEM_RDATA;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        ID_READY;
  logic        ID_VALID;
  logic [31:0] ID_INSTR;
  logic [31:0] ID_PC;
  logic [4:0]  ID_OPCODE;
`ifdef FETCH_PERF_EN
  logic [31:0] FETCH_CNT;
  logic [31:0] DROP_CNT;
`endif

  fetch_queue #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_GNT(IMEM_GNT),
    .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
    .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .ID_READY(ID_READY), .ID_VALID(ID_VALID), .ID_INSTR(ID_INSTR),
    .ID_PC(ID_PC), .ID_OPCODE(ID_OPCODE)
`ifdef FETCH_PERF_EN
    , .FETCH_CNT(FETCH_CNT), .DROP_CNT(DROP_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] pc; logic [31:0] instr; bit filled; int fcyc; } ent_t;
  typedef struct { int due; logic [31:0] addr; int gen; } req_t;

  ent_t sb[$];
  req_t mq[$];
  int   errors = 0, checks = 0, cyc = 0, gen = 0, pops_m = 0, drops_m = 0;
  bit   started = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: compares the decode interface against the head of the scoreboard
  always @(negedge CLK) begin
    bit expv;
    #2;
    if (started && !RST && !REDIRECT) begin
      expv = (sb.size() > 0) && sb[0].filled && (sb[0].fcyc < cyc);
      chk("id_valid", ID_VALID, expv);
      if (expv && ID_VALID) begin
        chk("id_pc", ID_PC, sb[0].pc);
        chk("id_instr", ID_INSTR, sb[0].instr);
        chk("id_opcode", ID_OPCODE, sb[0].instr[6:2]);
        if (ID_READY) begin
          void'(sb.pop_front());
          pops_m++;
        end
      end
    end
  end

  // Driver, memory model and fetch-PC model
  initial begin
    logic [31:0] mpc, tgt;
    int lat, lastdue;
    bit gnt, rdy, redir, rv, exp_req, grant, discarded;
    req_t resp;

    RST = 1'b1; IMEM_GNT = 0; IMEM_RVALID = 0; IMEM_RDATA = 0;
    REDIRECT = 0; REDIRECT_PC = 0; ID_READY = 0;
    mpc = RPC; lat = 1; lastdue = 0;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_req", IMEM_REQ, 0);
    chk("rst_addr", IMEM_ADDR, RPC);
    chk("rst_valid", ID_VALID, 0);
    chk("rst_instr", ID_INSTR, 0);
    chk("rst_pc", ID_PC, 0);
    chk("rst_opcode", ID_OPCODE, 0);
    started = 1;

    for (int c = 0; c < NCYC; c++) begin
      @(negedge CLK);
      cyc = c;
      redir = 0; tgt = 0; gnt = 1; rdy = 1;
      if (c < 40) lat = 1;
      else if (c < 50) rdy = 0;
      else if (c < 60) rdy = 1;
      else if (c < 80) gnt = !(c >= 65 && c < 70);
      else if (c < 100) begin
        lat = 3;
        if (c == 90) begin redir = 1; tgt = 32'h0000_0103; end
      end else begin
        if (c % 50 == 0) lat = 1 + $urandom_range(0, 2);
        gnt   = ($urandom_range(0, 3) != 0);
        rdy   = ($urandom_range(0, 3) != 0);
        redir = ($urandom_range(0, 15) == 0);
        tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF4 | 32'($urandom_range(0, 3))) : $urandom();
      end

      if (c == 1000 || c == 1001) begin
        RST = 1'b1; IMEM_GNT = 0; IMEM_RVALID = 0; REDIRECT = 0; ID_READY = 1;
        #1;
        chk("mid_rst_req", IMEM_REQ, 0);
        chk("mid_rst_addr", IMEM_ADDR, RPC);
        if (c == 1001) begin
          chk("mid_rst_valid", ID_VALID, 0);
          chk("mid_rst_instr", ID_INSTR, 0);
          chk("mid_rst_pc", ID_PC, 0);
`ifdef FETCH_PERF_EN
          chk("perf_rst_fetch", FETCH_CNT, 0);
          chk("perf_rst_drop", DROP_CNT, 0);
`endif
        end
        sb.delete(); mq.delete(); gen++; mpc = RPC; lastdue = 0;
        pops_m = 0; drops_m = 0;
        continue;
      end

      rv = (mq.size() > 0) && (mq[0].due <= c);
      RST = 1'b0;
      IMEM_GNT = gnt; ID_READY = rdy; REDIRECT = redir; REDIRECT_PC = tgt;
      IMEM_RVALID = rv;
      IMEM_RDATA = rv ? memf(mq[0].addr) : 32'h0;
      #1;

      exp_req = (sb.size() < DEPTH);
      chk("imem_req", IMEM_REQ, exp_req);
      if (exp_req) chk("imem_addr", IMEM_ADDR, mpc);
      grant = exp_req && gnt;

      if (rv) begin
        resp = mq.pop_front();
        discarded = redir || (resp.gen != gen);
        if (discarded) drops_m++;
        else begin
          for (int i = 0; i < sb.size(); i++)
            if (!sb[i].filled) begin
              sb[i].filled = 1; sb[i].fcyc = c;
              break;
            end
        end
      end
      if (grant) begin
        lastdue = (c + lat > lastdue) ? c + lat : lastdue + 1;
        mq.push_back('{lastdue, IMEM_ADDR, gen});
        if (!redir) begin
          sb.push_back('{mpc, memf(mpc), 0, 0});
          mpc = mpc + 32'd4;
        end
      end
      if (redir) begin
        sb.delete(); gen++;
        mpc = {tgt[31:2], 2'b00};
      end
    end

    @(negedge CLK);
    IMEM_GNT = 0; ID_READY = 0; REDIRECT = 0; IMEM_RVALID = 0;
    #3;
`ifdef FETCH_PERF_EN
    chk("perf_fetch", FETCH_CNT, pops_m);
    chk("perf_drop", DROP_CNT, drops_m);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
